change_dispense_ctrl: RTL

Sequences the coin-return hopper after a vend: it accepts a change amount in cents over a valid/ready handshake and pays it out greedily in 25/10/5-cent coins. It pulses one hopper solenoid at a time, confirms each coin with the drop sensor, tracks per-tube coin inventory, and reports completion or faults. It sits between the vend FSM's change value and the hopper actuators.

---
 rtl/vend_pkg.sv | 60 ++++++
 rtl/change_dispense_ctrl_if.sv | 38 +++
 rtl/cyc_timer.sv | 35 +++
 rtl/change_dispense_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared types and constants for the change dispenser.
//   COIN_25/COIN_10/COIN_5 : coin values in cents
//   state_t                : controller FSM states
//   err_code_t             : fault cause reported on err_code
//   denom_t                : selected denomination; its value doubles as the
//                            tube index (0 = 25c, 1 = 10c, 2 = 5c)
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam logic [7:0] COIN_25 = 8'd25;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_5  = 8'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_WAIT_SENSE,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_EMPTY   = 2'b01,
        ERR_RESIDUE = 2'b10,
        ERR_JAM     = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        DEN_25   = 2'd0,
        DEN_10   = 2'd1,
        DEN_5    = 2'd2,
        DEN_NONE = 2'd3
    } denom_t;

    function automatic logic [7:0] coin_value(input denom_t d);
        case (d)
            DEN_25:  return COIN_25;
            DEN_10:  return COIN_10;
            DEN_5:   return COIN_5;
            default: return 8'd0;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter holds at most max_val-1, so clog2(max_val) bits suffice.
    function automatic int timer_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl_if
// Request handshake, hopper actuator/sensor and status bundle.
//   master : vend FSM / hopper side (drives request, refill, coin_sense)
//   slave  : change_dispense_ctrl (drives ejects, status, tube counts)
// -----------------------------------------------------------------------------
interface change_dispense_ctrl_if;

    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       refill;
    logic       coin_sense;
    logic       eject_25;
    logic       eject_10;
    logic       eject_5;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] remaining;
    logic [7:0] tube_cnt_25;
    logic [7:0] tube_cnt_10;
    logic [7:0] tube_cnt_5;

    modport master (
        output req_valid, req_amount, refill, coin_sense,
        input  req_ready, eject_25, eject_10, eject_5, busy, done, err,
               err_code, remaining, tube_cnt_25, tube_cnt_10, tube_cnt_5
    );

    modport slave (
        input  req_valid, req_amount, refill, coin_sense,
        output req_ready, eject_25, eject_10, eject_5, busy, done, err,
               err_code, remaining, tube_cnt_25, tube_cnt_10, tube_cnt_5
    );

endinterface

// File: rtl/cyc_timer.sv
// -----------------------------------------------------------------------------
// cyc_timer
// Loadable down-counter. Loading N-1 on i_start makes o_expire high in the
// N-th cycle after the load edge, so a state entered together with the load
// lasts exactly N cycles when it leaves on o_expire.
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : load i_load_val this cycle
//   i_load_val  : value loaded on i_start
//   o_expire    : counter has reached zero
// -----------------------------------------------------------------------------
module cyc_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
// Pays a change amount out greedily in 25/10/5-cent coins, one solenoid
// pulse per coin, confirming each coin on the drop sensor and tracking the
// per-tube inventory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : change_dispense_ctrl_if.slave
//              in : req_valid, req_amount, refill, coin_sense
//              out: req_ready, eject_25/10/5, busy, done, err, err_code,
//                   remaining, tube_cnt_25/10/5
// -----------------------------------------------------------------------------
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 16,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TUBE_INIT   = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    change_dispense_ctrl_if.slave bus
);

    localparam int         TMR_MAX   = max3(PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam int         TMR_W     = timer_width(TMR_MAX);
    localparam logic [7:0] TUBE_FULL = 8'(TUBE_INIT);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_remaining;
    err_code_t  r_err_code;
    denom_t     r_denom;
    logic       r_sensed;

    denom_t           w_pick;
    logic [7:0]       w_coin_val;
    logic [2:0][7:0]  w_tube;
    logic [2:0]       w_eject;
    logic             w_req_ready;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_err;
    logic             w_tmr_start;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_expire;

    assign w_accept   = bus.req_valid & w_req_ready;
    assign w_coin_val = coin_value(r_denom);

    // Greedy choice; a remaining of 0 never passes any of the >= tests.
    always_comb begin
        w_pick = DEN_NONE;
        if (r_remaining >= COIN_25 && w_tube[0] != 8'd0) begin
            w_pick = DEN_25;
        end else if (r_remaining >= COIN_10 && w_tube[1] != 8'd0) begin
            w_pick = DEN_10;
        end else if (r_remaining >= COIN_5 && w_tube[2] != 8'd0) begin
            w_pick = DEN_5;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_SELECT;
            end
            ST_SELECT: begin
                if (r_remaining == 8'd0)     w_state_next = ST_DONE;
                else if (w_pick != DEN_NONE) w_state_next = ST_PULSE;
                else                         w_state_next = ST_FAULT;
            end
            ST_PULSE: begin
                // A sense in the last pulse cycle still counts as latched.
                if (w_tmr_expire) begin
                    w_state_next = (r_sensed || bus.coin_sense) ? ST_GAP : ST_WAIT_SENSE;
                end
            end
            ST_WAIT_SENSE: begin
                if (bus.coin_sense)    w_state_next = ST_GAP;
                else if (w_tmr_expire) w_state_next = ST_FAULT;
            end
            ST_GAP: begin
                if (w_tmr_expire) w_state_next = ST_SELECT;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            ST_FAULT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_req_ready = (r_state == ST_IDLE) && !bus.refill;
        w_busy      = (r_state != ST_IDLE);
        w_done      = (r_state == ST_DONE);
        w_err       = (r_state == ST_FAULT);
    end

    // The shared timer is loaded on every entry into a timed state.
    always_comb begin
        w_tmr_start = 1'b0;
        w_tmr_val   = '0;
        if (w_state_next != r_state) begin
            case (w_state_next)
                ST_PULSE: begin
                    w_tmr_start = 1'b1;
                    w_tmr_val   = TMR_W'(PULSE_CYC - 1);
                end
                ST_WAIT_SENSE: begin
                    w_tmr_start = 1'b1;
                    w_tmr_val   = TMR_W'(TIMEOUT_CYC - 1);
                end
                ST_GAP: begin
                    w_tmr_start = 1'b1;
                    w_tmr_val   = TMR_W'(GAP_CYC - 1);
                end
                default: ;
            endcase
        end
    end

    cyc_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_tmr_start),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= 8'd0;
            r_err_code  <= ERR_NONE;
            r_denom     <= DEN_NONE;
            r_sensed    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= bus.req_amount;
                        r_err_code  <= ERR_NONE;
                    end
                end
                ST_SELECT: begin
                    r_sensed <= 1'b0;
                    r_denom  <= w_pick;
                    if (r_remaining != 8'd0 && w_pick == DEN_NONE) begin
                        r_err_code <= (r_remaining < COIN_5) ? ERR_RESIDUE : ERR_EMPTY;
                    end
                end
                ST_PULSE: begin
                    // Only the first sense per coin is credited.
                    if (bus.coin_sense && !r_sensed) begin
                        r_sensed    <= 1'b1;
                        r_remaining <= r_remaining - w_coin_val;
                    end
                end
                ST_WAIT_SENSE: begin
                    if (bus.coin_sense) begin
                        r_remaining <= r_remaining - w_coin_val;
                    end else if (w_tmr_expire) begin
                        r_err_code <= ERR_JAM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-tube inventory and solenoid drive; index gi matches denom_t.
    // A dispensed coin is counted at selection and never restored on a jam.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tube
            logic [7:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= TUBE_FULL;
                end else if (r_state == ST_IDLE && bus.refill) begin
                    r_cnt <= TUBE_FULL;
                end else if (r_state == ST_SELECT && w_pick == denom_t'(gi)) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            assign w_tube[gi]  = r_cnt;
            assign w_eject[gi] = (r_state == ST_PULSE) && (r_denom == denom_t'(gi));
        end
    endgenerate

    assign bus.req_ready   = w_req_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.err         = w_err;
    assign bus.err_code    = r_err_code;
    assign bus.remaining   = r_remaining;
    assign bus.eject_25    = w_eject[0];
    assign bus.eject_10    = w_eject[1];
    assign bus.eject_5     = w_eject[2];
    assign bus.tube_cnt_25 = w_tube[0];
    assign bus.tube_cnt_10 = w_tube[1];
    assign bus.tube_cnt_5  = w_tube[2];

endmodule
